// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter, bundled as one interface.
// slave = arbiter view, master = pipeline/memory (environment) view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    logic              stall_if;
    logic              stall_dm;
    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_ready, mem_rdata,
        output if_rdata, if_valid,
        output dm_rdata, dm_valid,
        output stall_if, stall_dm, err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_ready, mem_rdata,
        input  if_rdata, if_valid,
        input  dm_rdata, dm_valid,
        input  stall_if, stall_dm, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_watchdog.sv
// ISSUE-phase timeout counter: cleared when a transaction is granted,
// counts every ISSUE cycle, flags the last permitted cycle.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned       CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear on grant, saturating increment while issuing.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage
// data port: arbitrates in IDLE, holds a registered request in ISSUE until the
// memory answers (or the watchdog expires), pulses completion in RESP.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              err_q, err_d;
    logic [3:0]        starve_q, starve_d;

    logic              fetch_wins;
    logic              wd_clear, wd_run, wd_expired;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .run_i     (wd_run),
        .expired_o (wd_expired)
    );

    // Data has priority unless fetch has already waited through STARVE_LIMIT data grants.
    assign fetch_wins = bus.if_req && (!bus.dm_req || (starve_q == STARVE_MAX));

    // FSM next state, request latches, completion pulses and read-data capture.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        mem_req_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        err_d      = 1'b0;
        wd_clear   = 1'b0;
        wd_run     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    wd_clear  = 1'b1;
                    if (fetch_wins) begin
                        // Fetch is a full-word read.
                        gnt_d   = GNT_IF;
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = '1;
                    end else begin
                        gnt_d   = GNT_DM;
                        addr_d  = bus.dm_addr;
                        we_d    = bus.dm_we;
                        wdata_d = bus.dm_wdata;
                        be_d    = bus.dm_be;
                    end
                end
            end
            ISSUE: begin
                wd_run = 1'b1;
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = bus.mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        if (!we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                        dm_valid_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = DATA_W'(ERR_DATA);
                        if_valid_d = 1'b1;
                    end else begin
                        dm_rdata_d = DATA_W'(ERR_DATA);
                        dm_valid_d = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: counts data grants made while fetch is waiting.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            if (fetch_wins) begin
                starve_d = '0;
            end else if (starve_q != '1) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            mem_req_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            err_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            mem_req_q  <= mem_req_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_dm  = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses,
// a negedge monitor checks the memory side and every completion pulse.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned TMO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_if[$];
    exp_t exp_dm[$];
    int   ord[$];       // observed completion order: 0 = fetch, 1 = data
    int   exp_ord[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] phys_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] last_dm = '0;

    int hang        = 0;
    int fixed_delay = -1;
    int mem_req_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    // Memory responder: random or fixed wait, or never answers when hang is set.
    initial begin : responder
        int wait_left;
        wait_left = -1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (!bus.mem_req || hang != 0) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0) wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = phys_rd(bus.mem_addr);
                    if (bus.mem_we)
                        phys_mem[bus.mem_addr] = merge(phys_rd(bus.mem_addr), bus.mem_wdata, bus.mem_be);
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Monitor: memory-side request contents and completion pulses.
    initial begin : monitor
        logic prev_if_v, prev_dm_v;
        exp_t e;
        prev_if_v = 1'b0;
        prev_dm_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.mem_req) begin
                    mem_req_cycles++;
                    if (bus.mem_addr < 32'h200) begin
                        if (exp_if.size() == 0) check("mem_req_unexpected_if", 32'(exp_if.size()), 32'd1);
                        else begin
                            check("mem_addr_if", bus.mem_addr, exp_if[0].addr);
                            check("mem_we_if", 32'(bus.mem_we), 32'd0);
                            check("mem_be_if", 32'(bus.mem_be), 32'hF);
                        end
                    end else begin
                        if (exp_dm.size() == 0) check("mem_req_unexpected_dm", 32'(exp_dm.size()), 32'd1);
                        else begin
                            check("mem_addr_dm", bus.mem_addr, exp_dm[0].addr);
                            check("mem_we_dm", 32'(bus.mem_we), 32'(exp_dm[0].we));
                            check("mem_be_dm", 32'(bus.mem_be), 32'(exp_dm[0].be));
                            if (exp_dm[0].we) check("mem_wdata_dm", bus.mem_wdata, exp_dm[0].wdata);
                        end
                    end
                end
                if (bus.if_valid) begin
                    check("if_valid_one_cycle", 32'(prev_if_v), 32'd0);
                    if (exp_if.size() == 0) check("if_valid_unexpected", 32'(exp_if.size()), 32'd1);
                    else begin
                        e = exp_if.pop_front();
                        check("if_rdata", bus.if_rdata, e.rdata);
                        check("if_err", 32'(bus.err), 32'(e.err));
                        ord.push_back(0);
                    end
                end
                if (bus.dm_valid) begin
                    check("dm_valid_one_cycle", 32'(prev_dm_v), 32'd0);
                    if (exp_dm.size() == 0) check("dm_valid_unexpected", 32'(exp_dm.size()), 32'd1);
                    else begin
                        e = exp_dm.pop_front();
                        check("dm_rdata", bus.dm_rdata, e.rdata);
                        check("dm_err", 32'(bus.err), 32'(e.err));
                        ord.push_back(1);
                    end
                end
                if (bus.err && !bus.if_valid && !bus.dm_valid)
                    check("err_without_valid", 32'(bus.err), 32'd0);
            end
            prev_if_v = bus.if_valid;
            prev_dm_v = bus.dm_valid;
        end
    end

    task automatic fetch_txn(input logic [31:0] a, input bit keep);
        exp_t e;
        bit   got;
        e.addr = a; e.we = 1'b0; e.wdata = '0; e.be = 4'hF;
        e.rdata = ref_rd(a); e.err = 1'b0;
        exp_if.push_back(e);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            got = bus.if_valid;
            check("stall_if", 32'(bus.stall_if), got ? 32'd0 : 32'd1);
        end
        check("if_valid_seen", 32'(got), 32'd1);
        if (!keep) bus.if_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input bit tmo, input bit keep);
        exp_t e;
        bit   got;
        e.addr = a; e.we = we; e.wdata = wd; e.be = be; e.err = tmo;
        if (tmo) begin
            e.rdata = 32'hDEADBEEF;
            last_dm = 32'hDEADBEEF;
        end else if (we) begin
            e.rdata = last_dm;
            ref_mem[a] = merge(ref_rd(a), wd, be);
        end else begin
            e.rdata = ref_rd(a);
            last_dm = e.rdata;
        end
        exp_dm.push_back(e);
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = wd;
        bus.dm_be    = be;
        bus.dm_req   = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            got = bus.dm_valid;
            check("stall_dm", 32'(bus.stall_dm), got ? 32'd0 : 32'd1);
        end
        check("dm_valid_seen", 32'(got), 32'd1);
        if (!keep) bus.dm_req = 1'b0;
    endtask

    // Expected completion order with fetch waiting behind nd back-to-back data requests.
    task automatic build_order(input int nd);
        int  consec;
        bit  fpend;
        exp_ord.delete();
        consec = 0;
        fpend  = 1'b1;
        for (int i = 0; i < nd; i++) begin
            if (fpend && consec == int'(LIMIT)) begin
                exp_ord.push_back(0);
                fpend  = 1'b0;
                consec = 0;
            end
            exp_ord.push_back(1);
            if (fpend) consec++;
        end
        if (fpend) exp_ord.push_back(0);
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_len"}, 32'(ord.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size() && i < ord.size(); i++)
            check({tag, "_grant"}, 32'(ord[i]), 32'(exp_ord[i]));
    endtask

    initial begin : global_timeout
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        exp_t e;
        int   vcount;
        bit   seen;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0;
        bus.dm_wdata = '0; bus.dm_be = '0;

        // Reset state.
        @(negedge clk);
        check("rst_mem_req",  32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
        check("rst_err",      32'(bus.err), 32'd0);
        check("rst_dm_rdata", bus.dm_rdata, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait fetch latency.
        fixed_delay = 0;
        e.addr = 32'h10; e.we = 1'b0; e.wdata = '0; e.be = 4'hF;
        e.rdata = ref_rd(32'h10); e.err = 1'b0;
        exp_if.push_back(e);
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        @(negedge clk);
        check("lat_mem_req_c1", 32'(bus.mem_req), 32'd1);
        check("lat_mem_addr_c1", bus.mem_addr, 32'h10);
        check("lat_if_valid_c1", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        check("lat_if_valid_c2", 32'(bus.if_valid), 32'd1);
        check("lat_mem_req_c2", 32'(bus.mem_req), 32'd0);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        fixed_delay = -1;

        // Simultaneous store + fetch: data first.
        ord.delete();
        build_order(1);
        fork
            fetch_txn(32'h20, 1'b0);
            data_txn(1'b1, 32'h200, 32'hA1B2C3D4, 4'b0110, 1'b0, 1'b0);
        join
        compare_order("pri");
        repeat (2) @(negedge clk);

        // Continuous data vs waiting fetch: starvation limit.
        ord.delete();
        build_order(6);
        fork
            fetch_txn(32'h40, 1'b0);
            for (int i = 0; i < 6; i++)
                data_txn(1'b0, 32'h200 + 32'(i * 4), '0, 4'hF, 1'b0, i < 5);
        join
        compare_order("starve");
        repeat (2) @(negedge clk);

        // Timeout on a load, then a store must leave dm_rdata untouched.
        hang = 1;
        mem_req_cycles = 0;
        data_txn(1'b0, 32'h300, '0, 4'hF, 1'b1, 1'b0);
        check("timeout_issue_cycles", 32'(mem_req_cycles), 32'(TMO));
        hang = 0;
        @(negedge clk);
        data_txn(1'b1, 32'h304, 32'h01020304, 4'hF, 1'b0, 1'b0);
        @(negedge clk);

        // Load with three wait cycles.
        fixed_delay = 3;
        mem_req_cycles = 0;
        data_txn(1'b0, 32'h200, '0, 4'hF, 1'b0, 1'b0);
        check("delay_issue_cycles", 32'(mem_req_cycles), 32'd4);
        fixed_delay = -1;
        @(negedge clk);

        // Randomized concurrent traffic.
        fork
            for (int i = 0; i < 30; i++) begin
                fetch_txn({23'd0, 7'($urandom_range(0, 127)), 2'b00}, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int i = 0; i < 40; i++) begin
                data_txn(1'($urandom_range(0, 1)), 32'h200 + {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                         $urandom, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        join
        repeat (2) @(negedge clk);

        // Reset in the middle of ISSUE.
        hang = 1;
        e.addr = 32'h44; e.we = 1'b0; e.wdata = '0; e.be = 4'hF;
        e.rdata = ref_rd(32'h44); e.err = 1'b0;
        exp_if.push_back(e);
        bus.if_addr = 32'h44;
        bus.if_req  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        check("rst_mid_issue_started", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("rst_mid_mem_req",  32'(bus.mem_req), 32'd0);
        check("rst_mid_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mid_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_mid_dm_rdata", bus.dm_rdata, 32'd0);
        check("rst_mid_if_rdata", bus.if_rdata, 32'd0);
        check("rst_mid_stall_if", 32'(bus.stall_if), 32'd0);
        exp_if.delete();
        exp_dm.delete();
        last_dm = '0;
        hang = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.if_valid || bus.dm_valid) vcount++;
        end
        check("rst_no_stale_valid", 32'(vcount), 32'd0);
        fetch_txn(32'h48, 1'b0);
        data_txn(1'b1, 32'h208, 32'h55AA55AA, 4'hF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("final_if_queue_empty", 32'(exp_if.size()), 32'd0);
        check("final_dm_queue_empty", 32'(exp_dm.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
